// File: rtl/rvfi_rob_pkg.sv
// rvfi_rob_pkg: shared constants and helpers for the RVFI reorder buffer.
//   ORDER_W       - width of rvfi_order tags handled by the buffer
//   TIMEOUT_LIMIT - head-stall cycle count that raises err_timeout
//   rob_dist()    - modular (mod 2^ORDER_W) distance of an order from head
package rvfi_rob_pkg;

    localparam int ORDER_W = 8;
    localparam logic [15:0] TIMEOUT_LIMIT = 16'd1023;

    // Distance of an incoming order ahead of head; wraps naturally in 8 bits.
    function automatic logic [ORDER_W-1:0] rob_dist(
        input logic [ORDER_W-1:0] order,
        input logic [ORDER_W-1:0] head
    );
        return order - head;
    endfunction

endpackage

// File: rtl/rvfi_rob_slots.sv
// rvfi_rob_slots: DEPTH-entry packet store for the reorder buffer.
// Ports:
//   clk, resetn         - clock, async active-low reset (clears occupancy)
//   wr_en/wr_idx        - write strobe and slot index
//   wr_order/wr_data    - packet stored into the slot
//   rd_en/rd_idx        - drain strobe (clears occupancy) and head slot index
//   rd_order/rd_data    - combinational read of the head slot
//   occ                 - per-slot occupied bits (registered)
module rvfi_rob_slots
    import rvfi_rob_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 256
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [ORDER_W-1:0]       wr_order,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [ORDER_W-1:0]       rd_order,
    output logic [DATA_W-1:0]        rd_data,
    output logic [DEPTH-1:0]         occ
);

    logic [DEPTH-1:0]   occ_r;
    logic [ORDER_W-1:0] order_mem_r [DEPTH];
    logic [DATA_W-1:0]  data_mem_r  [DEPTH];

    // Occupancy: drain clears head slot, write sets target slot (never the same slot).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            occ_r <= '0;
        end else begin
            if (rd_en) begin
                occ_r[rd_idx] <= 1'b0;
            end
            if (wr_en) begin
                occ_r[wr_idx] <= 1'b1;
            end
        end
    end

    // Payload storage; contents are only meaningful while the occ bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            order_mem_r[wr_idx] <= wr_order;
            data_mem_r[wr_idx]  <= wr_data;
        end
    end

    assign rd_order = order_mem_r[rd_idx];
    assign rd_data  = data_mem_r[rd_idx];
    assign occ      = occ_r;

endmodule

// File: rtl/rvfi_reorder_buffer.sv
// rvfi_reorder_buffer: accepts RVFI retirement packets out of order within a
// DEPTH-wide window and re-emits them strictly in ascending rvfi_order.
// Ports:
//   clk, resetn                     - clock, async active-low reset
//   in_valid/in_order/in_data       - incoming retirement packet
//   out_valid/out_order/out_data    - in-order registered output stream
//   level                           - number of occupied slots
//   err_dup/err_window/err_timeout  - sticky error flags
// Optional feature: define RVFI_ROB_TIMEOUT_EN to build the head-stall
// watchdog; otherwise err_timeout is tied low.
module rvfi_reorder_buffer
    import rvfi_rob_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 256
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    input  logic [7:0]               in_order,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    output logic [7:0]               out_order,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err_dup,
    output logic                     err_window,
    output logic                     err_timeout
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int LVL_W = IDX_W + 1;
    localparam logic [ORDER_W:0] DEPTH_LIM = (ORDER_W+1)'(DEPTH);

    logic [ORDER_W-1:0] head_r;
    logic               out_valid_r;
    logic [ORDER_W-1:0] out_order_r;
    logic [DATA_W-1:0]  out_data_r;
    logic [LVL_W-1:0]   level_r;
    logic               err_dup_r;
    logic               err_window_r;

    logic [ORDER_W-1:0] dist_s;
    logic               in_win_s;
    logic [IDX_W-1:0]   wr_idx_s;
    logic [IDX_W-1:0]   head_idx_s;
    logic [DEPTH-1:0]   occ_s;
    logic               wr_en_s;
    logic               rd_en_s;
    logic               dup_s;
    logic               win_err_s;
    logic [ORDER_W-1:0] rd_order_s;
    logic [DATA_W-1:0]  rd_data_s;

    assign dist_s     = rob_dist(in_order, head_r);
    assign in_win_s   = ({1'b0, dist_s} < DEPTH_LIM);
    assign wr_idx_s   = in_order[IDX_W-1:0];
    assign head_idx_s = head_r[IDX_W-1:0];
    // A write aimed at the draining head slot is necessarily a duplicate.
    assign rd_en_s    = occ_s[head_idx_s];
    assign wr_en_s    = in_valid & in_win_s & ~occ_s[wr_idx_s];
    assign dup_s      = in_valid & in_win_s & occ_s[wr_idx_s];
    assign win_err_s  = in_valid & ~in_win_s;

    rvfi_rob_slots #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_slots (
        .clk      (clk),
        .resetn   (resetn),
        .wr_en    (wr_en_s),
        .wr_idx   (wr_idx_s),
        .wr_order (in_order),
        .wr_data  (in_data),
        .rd_en    (rd_en_s),
        .rd_idx   (head_idx_s),
        .rd_order (rd_order_s),
        .rd_data  (rd_data_s),
        .occ      (occ_s)
    );

    // Drain the head slot into the output registers and advance head.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_r      <= 8'd0;
            out_valid_r <= 1'b0;
            out_order_r <= 8'd0;
            out_data_r  <= '0;
        end else if (rd_en_s) begin
            head_r      <= head_r + 8'd1;
            out_valid_r <= 1'b1;
            out_order_r <= rd_order_s;
            out_data_r  <= rd_data_s;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    // Occupancy count tracks occ on the same edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            level_r <= '0;
        end else begin
            case ({wr_en_s, rd_en_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Sticky protocol-error flags, cleared only by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_dup_r    <= 1'b0;
            err_window_r <= 1'b0;
        end else begin
            err_dup_r    <= err_dup_r | dup_s;
            err_window_r <= err_window_r | win_err_s;
        end
    end

`ifdef RVFI_ROB_TIMEOUT_EN
    logic [15:0] stall_cnt_r;
    logic        err_timeout_r;

    // Head-stall watchdog: counts cycles with data buffered but head missing.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_r   <= 16'd0;
            err_timeout_r <= 1'b0;
        end else begin
            if (rd_en_s) begin
                stall_cnt_r <= 16'd0;
            end else if ((level_r != LVL_W'(0)) && (stall_cnt_r != TIMEOUT_LIMIT)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end
            if (stall_cnt_r == TIMEOUT_LIMIT) begin
                err_timeout_r <= 1'b1;
            end
        end
    end

    assign err_timeout = err_timeout_r;
`else
    assign err_timeout = 1'b0;
`endif

    assign out_valid  = out_valid_r;
    assign out_order  = out_order_r;
    assign out_data   = out_data_r;
    assign level      = level_r;
    assign err_dup    = err_dup_r;
    assign err_window = err_window_r;

endmodule

// File: tb/tb_rvfi_reorder_buffer.sv
// Self-checking bench for rvfi_reorder_buffer (DEPTH=16, DATA_W=256).
// Driver pushes the expected in-order output stream into a queue; a negedge
// monitor pops and compares whenever out_valid is high.
module tb_rvfi_reorder_buffer;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 256;

    typedef struct {
        logic [7:0]        order;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk;
    logic              resetn;
    logic              in_valid;
    logic [7:0]        in_order;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [7:0]        out_order;
    logic [DATA_W-1:0] out_data;
    logic [4:0]        level;
    logic              err_dup;
    logic              err_window;
    logic              err_timeout;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_fail;
    int   max_level;

    rvfi_reorder_buffer #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_order    (in_order),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_order   (out_order),
        .out_data    (out_data),
        .level       (level),
        .err_dup     (err_dup),
        .err_window  (err_window),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mk_data(input logic [7:0] order, input logic [7:0] tag);
        return {{31{tag}}, order};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_out(input logic [7:0] order, input logic [7:0] tag);
        exp_t e;
        e.order = order;
        e.data  = mk_data(order, tag);
        exp_q.push_back(e);
    endtask

    // Drive one packet for one cycle; returns #1 after the sampling edge.
    task automatic send(input logic [7:0] order, input logic [7:0] tag);
        in_valid = 1'b1;
        in_order = order;
        in_data  = mk_data(order, tag);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        resetn   = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        resetn = 1'b1;
        #1;
        max_level = 0;
    endtask

    // Monitor: every valid output must match the next expected packet.
    always @(negedge clk) begin
        if (resetn) begin
            if (int'(level) > max_level) max_level = int'(level);
            if (out_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out: got order %0d with nothing expected at %0t", out_order, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (out_order !== e.order || out_data !== e.data) begin
                        n_fail++;
                        $display("FAIL out_pkt: got order %0d data %0h expected order %0d data %0h at %0t",
                                 out_order, out_data[31:0], e.order, e.data[31:0], $time);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] shuf [12];
        n_cmp     = 0;
        n_fail    = 0;
        max_level = 0;
        in_valid  = 1'b0;
        in_order  = 8'd0;
        in_data   = '0;
        resetn    = 1'b1;
        #2;
        do_reset();

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_order", 32'(out_order), 32'd0);
        chk("rst_out_data", out_data[31:0], 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_errs", {29'd0, err_dup, err_window, err_timeout}, 32'd0);

        // In-order 0..3: two-edge latency, level stays small
        for (int i = 0; i < 4; i++) expect_out(8'(i), 8'h11);
        send(8'd0, 8'h11);
        chk("lat_valid_e0", 32'(out_valid), 32'd0);
        chk("lat_level_e0", 32'(level), 32'd1);
        send(8'd1, 8'h11);
        chk("lat_valid_e1", 32'(out_valid), 32'd1);
        send(8'd2, 8'h11);
        send(8'd3, 8'h11);
        idle(4);
        chk("inorder_maxlvl_le2", 32'(max_level <= 2), 32'd1);
        chk("inorder_maxlvl_ge1", 32'(max_level >= 1), 32'd1);
        chk("inorder_drained", 32'(exp_q.size()), 32'd0);

        // Out of order 2,0,3,1
        do_reset();
        for (int i = 0; i < 4; i++) expect_out(8'(i), 8'h22);
        send(8'd2, 8'h22);
        chk("ooo_wait_2", 32'(out_valid), 32'd0);
        send(8'd0, 8'h22);
        chk("ooo_wait_0", 32'(out_valid), 32'd0);
        send(8'd3, 8'h22);
        send(8'd1, 8'h22);
        idle(6);
        chk("ooo_errs", {30'd0, err_dup, err_window}, 32'd0);
        chk("ooo_drained", 32'(exp_q.size()), 32'd0);
        chk("ooo_level", 32'(level), 32'd0);

        // Wrap across 255 -> 0 with shuffled groups of four
        do_reset();
        for (int i = 0; i < 250; i++) begin
            expect_out(8'(i), 8'h33);
            send(8'(i), 8'h33);
        end
        shuf = '{8'd252, 8'd250, 8'd253, 8'd251, 8'd255, 8'd1, 8'd254, 8'd0, 8'd4, 8'd2, 8'd5, 8'd3};
        for (int i = 0; i < 12; i++) expect_out(8'(250 + i), 8'h44);
        for (int i = 0; i < 12; i++) send(shuf[i], 8'h44);
        idle(6);
        chk("wrap_errs", {30'd0, err_dup, err_window}, 32'd0);
        chk("wrap_drained", 32'(exp_q.size()), 32'd0);

        // Window violation: order DEPTH with head at 0
        do_reset();
        send(8'd16, 8'h55);
        chk("win_err", 32'(err_window), 32'd1);
        chk("win_level", 32'(level), 32'd0);
        idle(3);
        expect_out(8'd0, 8'h55);
        send(8'd0, 8'h55);
        idle(3);
        chk("win_sticky", 32'(err_window), 32'd1);
        chk("win_no_dup", 32'(err_dup), 32'd0);
        chk("win_drained", 32'(exp_q.size()), 32'd0);

        // Duplicate order 5: first payload kept
        do_reset();
        for (int i = 0; i < 5; i++) expect_out(8'(i), 8'h66);
        expect_out(8'd5, 8'hA1);
        send(8'd5, 8'hA1);
        chk("dup_clear_first", 32'(err_dup), 32'd0);
        send(8'd5, 8'hB2);
        chk("dup_err", 32'(err_dup), 32'd1);
        chk("dup_level", 32'(level), 32'd1);
        for (int i = 0; i < 5; i++) send(8'(i), 8'h66);
        idle(6);
        chk("dup_no_win", 32'(err_window), 32'd0);
        chk("dup_drained", 32'(exp_q.size()), 32'd0);

        // Head stall: order 1 only
        do_reset();
        send(8'd1, 8'h77);
`ifdef RVFI_ROB_TIMEOUT_EN
        idle(1023);
        chk("timeout_before", 32'(err_timeout), 32'd0);
        idle(1);
        chk("timeout_at", 32'(err_timeout), 32'd1);
`else
        idle(1100);
        chk("timeout_off", 32'(err_timeout), 32'd0);
`endif
        chk("stall_level", 32'(level), 32'd1);

        // Reset mid-operation discards the buffered packet
        do_reset();
        chk("midrst_level", 32'(level), 32'd0);
        idle(20);
        chk("midrst_idle_level", 32'(level), 32'd0);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
